imem_arbiter: RTL and testbench

- Owns the single port of the instruction memory (1024 x 32-bit words, word-addressed; synchronous read, 1-cycle latency; synchronous write).
- After reset, the boot loader has exclusive write access to fill the program.
- Once the loader signals completion, the memory is shared round-robin between the core fetch stage and the debug read port, and the core is released (core_run).
- A reload request drains any in-flight read and returns ownership to the loader.

---
 rtl/imem_arbiter_pkg.sv | 24 ++
 rtl/imem_arbiter_arb2.sv | 51 +++++
 rtl/imem_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int DEPTH_LOG2_DEF = 10;

    // A byte address is unusable if it is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [63:0] addr, input int unsigned depth_log2);
        logic [63:0] above;
        above = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (above != 64'd0);
    endfunction

endpackage

// File: rtl/imem_arbiter_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter2
    import imem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_dbg,
    output logic gnt_if,
    output logic gnt_dbg
);

    owner_e last_grant_q;
    owner_e last_grant_d;

    // Pick a winner when enabled and remember who won.
    always_comb begin
        gnt_if       = 1'b0;
        gnt_dbg      = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            if (req_if && req_dbg) begin
                if (last_grant_q == OWN_IF) begin
                    gnt_dbg = 1'b1;
                end else begin
                    gnt_if = 1'b1;
                end
            end else if (req_if) begin
                gnt_if = 1'b1;
            end else if (req_dbg) begin
                gnt_dbg = 1'b1;
            end
        end
        if (gnt_if) begin
            last_grant_d = OWN_IF;
        end else if (gnt_dbg) begin
            last_grant_d = OWN_DBG;
        end
    end

    // Last-grant register; reset favours fetch on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory owner: loader fill, then round-robin fetch/debug reads.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  ld_done,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,
    output logic                  if_rsp_err,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic                  dbg_rsp_valid,
    output logic [DATA_W-1:0]     dbg_rsp_data,
    output logic                  dbg_rsp_err,
    output logic                  core_run,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e state_q;
    state_e state_d;
    logic   core_run_q;
    logic   core_run_d;
    logic   rsp_vld_q;
    logic   rsp_vld_d;
    owner_e rsp_own_q;
    owner_e rsp_own_d;
    logic   rsp_err_q;
    logic   rsp_err_d;

    logic              arb_en;
    logic              gnt_if;
    logic              gnt_dbg;
    logic              grant;
    logic              gnt_bad;
    logic [ADDR_W-1:0] gnt_addr;
    logic              if_bad;
    logic              dbg_bad;
    logic              ld_bad;
    logic              rsp_live;

    // Reads are only arbitrated while running and never while reset is held.
    assign arb_en = (state_q == RUN) && !rst;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .req_if  (if_req_valid),
        .req_dbg (dbg_req_valid),
        .gnt_if  (gnt_if),
        .gnt_dbg (gnt_dbg)
    );

    // Address checks and selection of the granted request.
    always_comb begin
        if_bad   = addr_bad(64'(if_addr), DEPTH_LOG2);
        dbg_bad  = addr_bad(64'(dbg_addr), DEPTH_LOG2);
        ld_bad   = addr_bad(64'(ld_addr), DEPTH_LOG2);
        grant    = gnt_if || gnt_dbg;
        gnt_bad  = gnt_if ? if_bad : dbg_bad;
        gnt_addr = gnt_if ? if_addr : dbg_addr;
    end

    // Ownership FSM next state; core_run follows the state being entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_done) state_d = RUN;
            RUN:     if (ld_start) state_d = DRAIN;
            DRAIN:   state_d = LOAD;
            default: state_d = LOAD;
        endcase
        core_run_d = (state_d == RUN);
    end

    // Memory port drive: loader writes in LOAD, granted reads in RUN; bad addresses touch nothing.
    always_comb begin
        ld_ready      = (state_q == LOAD) && !rst;
        if_req_ready  = gnt_if;
        dbg_req_ready = gnt_dbg;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (ld_ready && ld_valid) begin
            if (!ld_bad) begin
                mem_we    = 1'b1;
                mem_addr  = ld_addr[DEPTH_LOG2+1:2];
                mem_wdata = ld_data;
            end
        end else if (grant && !gnt_bad) begin
            mem_addr = gnt_addr[DEPTH_LOG2+1:2];
        end
    end

    // Response tag captured at grant time for the following cycle.
    always_comb begin
        rsp_vld_d = grant;
        rsp_own_d = gnt_dbg ? OWN_DBG : OWN_IF;
        rsp_err_d = grant && gnt_bad;
    end

    // State, core_run and response-tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            core_run_q <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_own_q  <= OWN_IF;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_run_q <= core_run_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_own_q  <= rsp_own_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Response steering: read data goes to the tagged owner; errors and idle cycles return zero.
    always_comb begin
        rsp_live      = rsp_vld_q && !rst;
        core_run      = core_run_q;
        if_rsp_valid  = rsp_live && (rsp_own_q == OWN_IF);
        dbg_rsp_valid = rsp_live && (rsp_own_q == OWN_DBG);
        if_rsp_err    = if_rsp_valid && rsp_err_q;
        dbg_rsp_err   = dbg_rsp_valid && rsp_err_q;
        if_rsp_data   = (if_rsp_valid && !rsp_err_q) ? mem_rdata : '0;
        dbg_rsp_data  = (dbg_rsp_valid && !rsp_err_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1024x32 synchronous memory.
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic [31:0] dbg_addr;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic        dbg_rsp_err;
    logic        core_run;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] prog [3];

    int n_chk = 0;
    int n_err = 0;

    imem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ld_start      (ld_start),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_done       (ld_done),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_ready (dbg_req_ready),
        .dbg_addr      (dbg_addr),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .dbg_rsp_err   (dbg_rsp_err),
        .core_run      (core_run),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_dbg;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00a00113;
        prog[2] = 32'h002081b3;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1; ld_start = 0; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
        if_req_valid = 0; if_addr = 0; dbg_req_valid = 0; dbg_addr = 0;

        // Reset held: every ready forced low even with requests present.
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1; if_req_valid = 1; dbg_req_valid = 1;
        #1;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_dbg_ready", dbg_req_ready, 0);
        chk("rst_core_run", core_run, 0);
        chk("rst_if_rsp", if_rsp_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        ld_valid = 0; if_req_valid = 0; dbg_req_valid = 0; rst = 0;
        tick();

        // Program load.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_addr = 32'(i * 4); ld_data = prog[i]; if_req_valid = 1; if_addr = 0;
            #1;
            chk("ld_we", mem_we, 1);
            chk("ld_addr_idx", 32'(mem_addr), 32'(i));
            chk("ld_wdata", mem_wdata, prog[i]);
            chk("ld_ready", ld_ready, 1);
            chk("ld_if_ready", if_req_ready, 0);
            chk("ld_core_run", core_run, 0);
            tick();
        end
        ld_addr = 32'h2; ld_data = 32'hdeadbeef;
        #1;
        chk("ld_mis_ready", ld_ready, 1);
        chk("ld_mis_we", mem_we, 0);
        tick();
        ld_addr = 32'h1000;
        #1;
        chk("ld_oor_we", mem_we, 0);
        tick();

        ld_valid = 0; if_req_valid = 0; ld_done = 1;
        tick();
        ld_done = 0;
        chk("run_core_run", core_run, 1);
        chk("run_ld_ready", ld_ready, 0);

        // Single fetch of word 1.
        if_req_valid = 1; if_addr = 32'h4;
        #1;
        chk("f4_ready", if_req_ready, 1);
        chk("f4_mem_addr", 32'(mem_addr), 1);
        chk("f4_mem_we", mem_we, 0);
        tick();
        chk("f4_rsp_valid", if_rsp_valid, 1);
        chk("f4_rsp_data", if_rsp_data, 32'h00a00113);
        chk("f4_rsp_err", if_rsp_err, 0);
        chk("f4_dbg_valid", dbg_rsp_valid, 0);
        if_req_valid = 0;
        tick();
        chk("idle_if_valid", if_rsp_valid, 0);
        chk("idle_if_data", if_rsp_data, 0);

        // Both requesting every cycle: last grant was IF, so DBG first.
        if_req_valid = 1; if_addr = 32'h0; dbg_req_valid = 1; dbg_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            exp_dbg = (k % 2 == 0);
            #1;
            chk("rr_if_ready", if_req_ready, !exp_dbg);
            chk("rr_dbg_ready", dbg_req_ready, exp_dbg);
            chk("rr_mem_addr", 32'(mem_addr), exp_dbg ? 32'd2 : 32'd0);
            tick();
            chk("rr_if_valid", if_rsp_valid, !exp_dbg);
            chk("rr_dbg_valid", dbg_rsp_valid, exp_dbg);
            chk("rr_if_data", if_rsp_data, exp_dbg ? 32'h0 : 32'h00500093);
            chk("rr_dbg_data", dbg_rsp_data, exp_dbg ? 32'h002081b3 : 32'h0);
        end
        if_req_valid = 0; dbg_req_valid = 0;

        // Error addresses.
        if_req_valid = 1; if_addr = 32'h6;
        #1;
        chk("e6_ready", if_req_ready, 1);
        tick();
        chk("e6_valid", if_rsp_valid, 1);
        chk("e6_err", if_rsp_err, 1);
        chk("e6_data", if_rsp_data, 0);
        if_addr = 32'h1000;
        #1;
        chk("e1000_ready", if_req_ready, 1);
        tick();
        chk("e1000_valid", if_rsp_valid, 1);
        chk("e1000_err", if_rsp_err, 1);
        chk("e1000_data", if_rsp_data, 0);
        if_req_valid = 0; dbg_req_valid = 1; dbg_addr = 32'hfffffffc;
        #1;
        chk("edbg_ready", dbg_req_ready, 1);
        tick();
        chk("edbg_valid", dbg_rsp_valid, 1);
        chk("edbg_err", dbg_rsp_err, 1);
        chk("edbg_data", dbg_rsp_data, 0);
        chk("edbg_if_valid", if_rsp_valid, 0);
        dbg_req_valid = 0;

        // Reload while a fetch is granted: response still returns during DRAIN.
        if_req_valid = 1; if_addr = 32'h8; ld_start = 1;
        #1;
        chk("rl_ready", if_req_ready, 1);
        chk("rl_ld_ready", ld_ready, 0);
        tick();
        ld_start = 0;
        chk("rl_rsp_valid", if_rsp_valid, 1);
        chk("rl_rsp_data", if_rsp_data, 32'h002081b3);
        chk("rl_core_run", core_run, 0);
        chk("rl_drain_if_ready", if_req_ready, 0);
        chk("rl_drain_ld_ready", ld_ready, 0);
        tick();
        chk("rl_load_ld_ready", ld_ready, 1);
        chk("rl_load_if_ready", if_req_ready, 0);
        chk("rl_load_rsp", if_rsp_valid, 0);
        chk("rl_load_core_run", core_run, 0);

        // ld_start and ld_done together in LOAD: ld_done wins.
        if_req_valid = 0; ld_start = 1; ld_done = 1;
        tick();
        ld_start = 0; ld_done = 0;
        chk("both_core_run", core_run, 1);
        chk("both_ld_ready", ld_ready, 0);

        // Reset right after a grant drops the response.
        if_req_valid = 1; if_addr = 32'h4;
        #1;
        chk("rg_ready", if_req_ready, 1);
        tick();
        rst = 1; if_req_valid = 0;
        #1;
        chk("rg_rsp_valid", if_rsp_valid, 0);
        chk("rg_rsp_data", if_rsp_data, 0);
        chk("rg_ld_ready", ld_ready, 0);
        tick();
        rst = 0;
        chk("rg_core_run", core_run, 0);
        chk("rg_if_valid", if_rsp_valid, 0);
        chk("rg_err", if_rsp_err, 0);
        chk("rg_mem_we", mem_we, 0);
        #1;
        chk("rg_ld_ready_after", ld_ready, 1);
        chk("rg_if_ready_after", if_req_ready, 0);

        // last_grant was reset to DBG, so a tie goes to IF.
        ld_done = 1;
        tick();
        ld_done = 0;
        if_req_valid = 1; if_addr = 32'h0; dbg_req_valid = 1; dbg_addr = 32'h4;
        #1;
        chk("rst_tie_if", if_req_ready, 1);
        chk("rst_tie_dbg", dbg_req_ready, 0);
        tick();
        if_req_valid = 0; dbg_req_valid = 0;
        chk("rst_tie_data", if_rsp_data, 32'h00500093);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
